// File: rtl/test_harness_pkg.sv
// Shared types and helpers for the built-in scratch RAM self-test.
package test_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE,
    FAIL
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // One step of the 32-bit Galois LFSR that generates the test pattern.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/harness_sram.sv
// 1R1W scratch RAM: synchronous write, registered read (1-cycle latency), no reset.
module harness_sram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/test_harness.sv
// Memory self-test harness: two LFSR write/read-back passes (true, then inverted data).
// Optional TEST_HARNESS_FAULT_INJECT_EN flips read bit 0 at address 5 in pass 0.
module test_harness
  import test_harness_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  state_t            state_reg, state_next;
  logic              pass_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       lfsr_reg;
  logic [DATA_W-1:0] exp_reg;
  logic              chk_reg;
  logic              success_reg;

  logic              we;
  logic              success_next;
  logic              last_addr;
  logic              mismatch;
  logic [DATA_W-1:0] pass_data;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rdata_chk;

  assign last_addr = &addr_reg;
  assign pass_data = pass_reg ? ~lfsr_reg : lfsr_reg;

  harness_sram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sram (
    .clock(clock),
    .we   (we),
    .waddr(addr_reg),
    .wdata(pass_data),
    .raddr(addr_reg),
    .rdata(rdata)
  );

`ifdef TEST_HARNESS_FAULT_INJECT_EN
  logic [ADDR_W-1:0] rd_addr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_reg <= '0;
    end else if (state_reg == READ) begin
      rd_addr_reg <= addr_reg;
    end
  end

  assign rdata_chk = rdata ^ {{(DATA_W-1){1'b0}}, (!pass_reg && (int'(rd_addr_reg) == 5))};
`else
  assign rdata_chk = rdata;
`endif

  // chk_reg marks the cycle in which rdata belongs to the previous cycle's read.
  assign mismatch = chk_reg && (rdata_chk != exp_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = WRITE;
      WRITE: if (last_addr) state_next = READ;
      READ: begin
        if (mismatch)       state_next = FAIL;
        else if (last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        if (mismatch)      state_next = FAIL;
        else if (pass_reg) state_next = DONE;
        else               state_next = WRITE;
      end
      DONE:    state_next = DONE;
      FAIL:    state_next = FAIL;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    we           = (state_reg == WRITE);
    success_next = (state_next == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_reg    <= 1'b0;
      addr_reg    <= '0;
      lfsr_reg    <= SEED;
      exp_reg     <= '0;
      chk_reg     <= 1'b0;
      success_reg <= 1'b0;
    end else begin
      success_reg <= success_next;
      chk_reg     <= (state_reg == READ);
      case (state_reg)
        IDLE: begin
          lfsr_reg <= SEED;
          addr_reg <= '0;
        end
        WRITE: begin
          if (last_addr) begin
            lfsr_reg <= SEED;
            addr_reg <= '0;
          end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
            addr_reg <= addr_reg + ADDR_W'(1);
          end
        end
        READ: begin
          exp_reg  <= pass_data;
          lfsr_reg <= lfsr_step(lfsr_reg);
          addr_reg <= addr_reg + ADDR_W'(1);
        end
        DRAIN: begin
          if (!pass_reg) begin
            pass_reg <= 1'b1;
            lfsr_reg <= SEED;
            addr_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_success = success_reg;

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: three parameterisations against a timing/LFSR model, with random reset pulses.
module tb_test_harness;

`ifdef TEST_HARNESS_FAULT_INJECT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  localparam logic [31:0] SEED_DEF = 32'hACE1_0001;
  localparam int NEVER = 1 << 30;

  // Edge (counted from reset release) after which io_success must read 1.
  function automatic int exp_edge(input int aw);
    int depth;
    depth = 1 << aw;
    if (FAULT && depth > 5) return NEVER;
    return 1 + 2 * (2 * depth + 1);
  endfunction

  // k-th word of the LFSR pattern starting from the (zero-promoted) seed.
  function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < k; i++) begin
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
    return s;
  endfunction

  localparam int E_DEF = exp_edge(6);
  localparam int E_S0  = exp_edge(6);
  localparam int E_A2  = exp_edge(2);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic succ_def, succ_s0, succ_a2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  test_harness #(.ADDR_W(6), .DATA_W(32), .LFSR_SEED(SEED_DEF)) dut_def (
    .clock(clock), .reset(reset), .io_success(succ_def));
  test_harness #(.ADDR_W(6), .DATA_W(32), .LFSR_SEED(32'h0)) dut_s0 (
    .clock(clock), .reset(reset), .io_success(succ_s0));
  test_harness #(.ADDR_W(2), .DATA_W(32), .LFSR_SEED(SEED_DEF)) dut_a2 (
    .clock(clock), .reset(reset), .io_success(succ_a2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run n edges after a reset release, checking success timing and RAM contents.
  task automatic run_phase(input int n);
    int k;
    for (int e = 1; e <= n; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("def_succ_e%0d", e), {31'b0, succ_def}, (e >= E_DEF) ? 32'd1 : 32'd0);
      check($sformatf("s0_succ_e%0d", e),  {31'b0, succ_s0},  (e >= E_S0)  ? 32'd1 : 32'd0);
      check($sformatf("a2_succ_e%0d", e),  {31'b0, succ_a2},  (e >= E_A2)  ? 32'd1 : 32'd0);
      if (e == 2) begin
        check("s0_first_word", dut_s0.u_sram.mem[0], 32'h1);
      end
      if (e == 65) begin
        k = $urandom_range(63);
        check("def_p0_addr0", dut_def.u_sram.mem[0], 32'hACE1_0001);
        check($sformatf("def_p0_addr%0d", k), dut_def.u_sram.mem[k], model_word(SEED_DEF, k));
        k = $urandom_range(63);
        check($sformatf("s0_p0_addr%0d", k), dut_s0.u_sram.mem[k], model_word(32'h0, k));
      end
      if (e == 194 && !FAULT) begin
        k = $urandom_range(63);
        check("def_p1_addr0", dut_def.u_sram.mem[0], 32'h531E_FFFE);
        check($sformatf("def_p1_addr%0d", k), dut_def.u_sram.mem[k], ~model_word(SEED_DEF, k));
      end
      if (e == 5) begin
        k = $urandom_range(3);
        check($sformatf("a2_p0_addr%0d", k), dut_a2.u_sram.mem[k], model_word(SEED_DEF, k));
      end
      if (e == 14) begin
        k = $urandom_range(3);
        check($sformatf("a2_p1_addr%0d", k), dut_a2.u_sram.mem[k], ~model_word(SEED_DEF, k));
      end
    end
  endtask

  // Assert reset mid-cycle, confirm the asynchronous clear, hold, release on a falling edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("async_clear_def", {31'b0, succ_def}, 32'd0);
    check("async_clear_s0",  {31'b0, succ_s0},  32'd0);
    check("async_clear_a2",  {31'b0, succ_a2},  32'd0);
    repeat ($urandom_range(1, 3)) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_def", {31'b0, succ_def}, 32'd0);
    check("reset_s0",  {31'b0, succ_s0},  32'd0);
    check("reset_a2",  {31'b0, succ_a2},  32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_phase(1300);
    pulse_reset();

    for (int it = 0; it < 4; it++) begin
      run_phase($urandom_range(100, 258));
      pulse_reset();
    end

    run_phase(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
